// File: rtl/add_sub_pipe.sv
// Purpose : pipelined ripple-carry adder/subtractor; WIDTH bits split into STAGES slices, one registered slice per stage.
// Latency : STAGES cycles from acceptance to out_valid; one beat per cycle sustained.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready; bubbles are not collapsed.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, c_in, sub)
//   sub                 0: a+b+c_in, 1: a-b (c_in ignored)
//   out_valid/out_ready result handshake (sum, c_out, overflow, zero)
//   c_out               carry out of MSB (in sub mode 1 = no borrow)
//   overflow            signed overflow; zero: sum == 0
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("add_sub_pipe: STAGES must be in 1..WIDTH and divide WIDTH evenly");
    end

    localparam int SW = WIDTH / STAGES;

    // A held result freezes the whole pipe, so no beat can overtake or overwrite it.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Subtraction is a + ~b + 1: invert b and force the stage-0 carry.
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    assign b_eff = sub ? ~b : b;
    assign cin0  = sub ? 1'b1 : c_in;

    // Inputs of the final slice (which also produces the flags).
    logic             fin_valid;
    logic [SW-1:0]    fin_a;
    logic [SW-1:0]    fin_b;
    logic             fin_cin;
    logic [SW:0]      fin_add;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_c_msb;

    assign fin_add = {1'b0, fin_a} + {1'b0, fin_b} + {{SW{1'b0}}, fin_cin};
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign fin_c_msb = fin_add[SW-1] ^ fin_a[SW-1] ^ fin_b[SW-1];

    if (STAGES == 1) begin : g_single
        assign fin_valid = in_valid;
        assign fin_a     = a;
        assign fin_b     = b_eff;
        assign fin_cin   = cin0;
        assign fin_sum   = fin_add[SW-1:0];
    end else begin : g_multi
        // Stage k registers hold: the operand bits still to be added (upper slices,
        // naturally skewed by k cycles), the sum slices already produced (lower slices,
        // riding along until the final stage), and the carry out of slice k.
        for (genvar k = 0; k < STAGES - 1; k++) begin : stg
            localparam int RW = WIDTH - (k + 1) * SW;   // operand bits left after this slice
            localparam int LW = (k + 1) * SW;           // sum bits completed through this slice

            logic          v_in;
            logic [SW-1:0] sl_a;
            logic [SW-1:0] sl_b;
            logic          sl_cin;
            logic [RW-1:0] rem_a;
            logic [RW-1:0] rem_b;
            logic [SW:0]   sl_sum;
            logic [LW-1:0] lo_next;

            logic          v_q;
            logic          c_q;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic [LW-1:0] lo_q;

            if (k == 0) begin : g_src
                assign v_in    = in_valid;
                assign sl_a    = a[SW-1:0];
                assign sl_b    = b_eff[SW-1:0];
                assign sl_cin  = cin0;
                assign rem_a   = a[WIDTH-1:SW];
                assign rem_b   = b_eff[WIDTH-1:SW];
                assign lo_next = sl_sum[SW-1:0];
            end else begin : g_mid
                assign v_in    = stg[k-1].v_q;
                assign sl_a    = stg[k-1].a_q[SW-1:0];
                assign sl_b    = stg[k-1].b_q[SW-1:0];
                assign sl_cin  = stg[k-1].c_q;
                assign rem_a   = stg[k-1].a_q[RW+SW-1:SW];
                assign rem_b   = stg[k-1].b_q[RW+SW-1:SW];
                assign lo_next = {sl_sum[SW-1:0], stg[k-1].lo_q};
            end

            assign sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{SW{1'b0}}, sl_cin};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q  <= 1'b0;
                    c_q  <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                end else if (!stall) begin
                    v_q  <= v_in;
                    c_q  <= sl_sum[SW];
                    a_q  <= rem_a;
                    b_q  <= rem_b;
                    lo_q <= lo_next;
                end
            end
        end

        assign fin_valid = stg[STAGES-2].v_q;
        assign fin_a     = stg[STAGES-2].a_q;
        assign fin_b     = stg[STAGES-2].b_q;
        assign fin_cin   = stg[STAGES-2].c_q;
        assign fin_sum   = {fin_add[SW-1:0], stg[STAGES-2].lo_q};
    end

    // Output register: the last stage. Data only loads for valid beats so the
    // visible result never changes under a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                sum      <= fin_sum;
                c_out    <= fin_add[SW];
                overflow <= fin_add[SW] ^ fin_c_msb;
                zero     <= (fin_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Purpose : directed self-checking bench for add_sub_pipe (8/2, 32/4 and 8/1 configurations).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready is scripted cycle by cycle to exercise stall and release.
module tb_add_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // WIDTH=8, STAGES=2
    logic       rst8, iv8, ir8, ci8, sub8, ov8, ordy8, co8, of8, z8;
    logic [7:0] a8, b8, sum8;
    // WIDTH=32, STAGES=4
    logic        rst32, iv32, ir32, ci32, sub32, ov32, ordy32, co32, of32, z32;
    logic [31:0] a32, b32, sum32;
    // WIDTH=8, STAGES=1 (shares rst8)
    logic       iv1, ir1, ci1, sub1, ov1, ordy1, co1, of1, z1;
    logic [7:0] a1, b1, sum1;

    add_sub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .c_in(ci8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(sum8),
        .c_out(co8), .overflow(of8), .zero(z8)
    );

    add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .reset(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .c_in(ci32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32), .sum(sum32),
        .c_out(co32), .overflow(of32), .zero(z32)
    );

    add_sub_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .reset(rst8), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .c_in(ci1), .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(sum1),
        .c_out(co1), .overflow(of1), .zero(z1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the 8/2 result visible this cycle, then advances one edge.
    task automatic expect8(input string tag, input logic [7:0] s, input logic c, input logic o, input logic z);
        @(negedge clk);
        check({tag, "_vld"}, ov8, 1'b1);
        check({tag, "_sum"}, sum8, s);
        check({tag, "_flags"}, {co8, of8, z8}, {c, o, z});
        step();
    endtask

    task automatic expect32(input string tag, input logic [31:0] s, input logic c, input logic o, input logic z);
        @(negedge clk);
        check({tag, "_vld"}, ov32, 1'b1);
        check({tag, "_sum"}, sum32, s);
        check({tag, "_flags"}, {co32, of32, z32}, {c, o, z});
        step();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1;
        rst32 = 1'b1; iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0; ordy1 = 1'b1;

        // ---- reset held for two cycles with in_valid toggling
        for (int i = 0; i < 2; i++) begin
            iv8 = (i == 0);
            a8  = 8'h55;
            b8  = 8'h33;
            @(negedge clk);
            check("rst_vld", ov8, 1'b0);
            check("rst_sum", sum8, 8'h00);
            check("rst_flags", {co8, of8, z8}, 3'b000);
            step();
        end
        rst8 = 1'b0; rst32 = 1'b0; iv8 = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", ir8, 1'b1);
        step();

        // ---- first beat after reset, two-cycle latency
        a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        @(negedge clk);
        check("lat_early_vld", ov8, 1'b0);
        step();
        expect8("first", 8'h11, 1'b0, 1'b0, 1'b0);

        // ---- carry across the slice boundary
        a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        step();
        expect8("slice_carry", 8'h10, 1'b0, 1'b0, 1'b0);

        // ---- full wrap through carry-in
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        step();
        expect8("wrap", 8'h00, 1'b1, 1'b0, 1'b1);

        // ---- signed overflow then subtraction, back to back
        a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        step();
        a8 = 8'h05; b8 = 8'h07; ci8 = 1'b1; sub8 = 1'b1;
        step();
        iv8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0;
        expect8("ovf", 8'h80, 1'b0, 1'b1, 1'b0);
        expect8("sub", 8'hFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_drain_vld", ov8, 1'b0);
        step();

        // ---- backpressure: 4 beats, 3 stalled cycles once the first result is out
        a8 = 8'h01; b8 = 8'h01; iv8 = 1'b1;
        step();
        a8 = 8'h02; b8 = 8'h02;
        @(negedge clk);
        check("bp_lat_vld", ov8, 1'b0);
        step();
        ordy8 = 1'b0;
        a8 = 8'h03; b8 = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_vld", ov8, 1'b1);
            check("bp_hold_sum", sum8, 8'h02);
            check("bp_hold_in_rdy", ir8, 1'b0);
            step();
        end
        ordy8 = 1'b1;
        @(negedge clk);
        check("bp_rel_in_rdy", ir8, 1'b1);
        check("bp_out0", {ov8, sum8}, {1'b1, 8'h02});
        step();
        a8 = 8'h04; b8 = 8'h04;
        @(negedge clk);
        check("bp_out1", {ov8, sum8}, {1'b1, 8'h04});
        step();
        iv8 = 1'b0;
        @(negedge clk);
        check("bp_out2", {ov8, sum8}, {1'b1, 8'h06});
        step();
        @(negedge clk);
        check("bp_out3", {ov8, sum8}, {1'b1, 8'h08});
        step();
        @(negedge clk);
        check("bp_drain_vld", ov8, 1'b0);
        step();

        // ---- single-stage configuration: latency 1
        a1 = 8'h7F; b1 = 8'h01; ci1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
        step();
        a1 = 8'h00; b1 = 8'h01; sub1 = 1'b1;
        @(negedge clk);
        check("s1_ovf_vld", ov1, 1'b1);
        check("s1_ovf_sum", sum1, 8'h80);
        check("s1_ovf_flags", {co1, of1, z1}, 3'b010);
        step();
        iv1 = 1'b0;
        @(negedge clk);
        check("s1_sub_sum", {ov1, sum1}, {1'b1, 8'hFF});
        check("s1_sub_flags", {co1, of1, z1}, 3'b000);
        step();
        @(negedge clk);
        check("s1_drain_vld", ov1, 1'b0);
        step();

        // ---- 32-bit / 4-stage stream, four-cycle latency
        a32 = 32'h89AB_CDEF; b32 = 32'h1234_5678; ci32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
        step();
        a32 = 32'h0000_0000; b32 = 32'h0000_0001; sub32 = 1'b1;
        step();
        a32 = 32'h8000_0000; b32 = 32'h0000_0001; sub32 = 1'b1;
        step();
        iv32 = 1'b0; sub32 = 1'b0;
        @(negedge clk);
        check("w32_lat_early_vld", ov32, 1'b0);
        step();
        expect32("w32_add", 32'h9BE0_2467, 1'b0, 1'b0, 1'b0);
        expect32("w32_neg", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        expect32("w32_sovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("w32_drain_vld", ov32, 1'b0);
        step();

        // ---- mid-flight reset: three beats in flight, then reset
        for (int i = 1; i <= 3; i++) begin
            a32 = i; b32 = i; sub32 = 1'b0; iv32 = 1'b1;
            step();
        end
        iv32 = 1'b0;
        rst32 = 1'b1;
        @(negedge clk);
        check("mid_rst_vld", ov32, 1'b0);
        check("mid_rst_sum", sum32, 32'h0);
        step();
        step();
        rst32 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_rst_no_stale", ov32, 1'b0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
